// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Data-hazard / forwarding controller beside the ID stage of an in-order
//   pipeline. Keeps a shadow record of in-flight register writes (entry 0 =
//   EXE ... entry STAGES-1 = WB) and from it produces either a stall-only
//   interlock (FWD_EN=0) or per-operand forwarding selects with a load-use
//   stall (FWD_EN=1). Also counts stall cycles (saturating).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   id_valid            valid instruction in ID
//   id_src1/2           source register addresses
//   id_src1/2_used      operand is actually read
//   id_dst, id_wb_en    destination register and write enable of ID instr
//   id_is_load          ID instruction is a load
//   freeze              whole pipeline held; shadow state holds
//   flush               ID instruction squashed; bubble enters entry 0
//   hazard              stall IF/ID, insert bubble into EXE (combinational)
//   fwd_sel1/2          0 = register file, k+1 = entry k (combinational)
//   stall_cnt           saturating stall-cycle counter (registered)
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W       = 5,
  parameter int unsigned STAGES           = 3,
  parameter bit          FWD_EN           = 1'b1,
  parameter bit          RF_WRITE_THROUGH = 1'b1,
  parameter int unsigned STAT_W           = 16,
  localparam int unsigned FS_W            = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_used,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_wb_en,
  input  logic                  id_is_load,
  input  logic                  freeze,
  input  logic                  flush,
  output logic                  hazard,
  output logic [FS_W-1:0]       fwd_sel1,
  output logic [FS_W-1:0]       fwd_sel2,
  output logic [STAT_W-1:0]     stall_cnt
);

  // Entries whose pending write is still invisible to an ID-stage RF read.
  localparam logic [STAGES-1:0] IL_MASK = RF_WRITE_THROUGH ?
                                          {1'b0, {(STAGES-1){1'b1}}} :
                                          {STAGES{1'b1}};

  // Shadow entries. Only entry 0 needs the load flag: a load is only a
  // hazard while it sits in EXE, from entry 1 onward it forwards.
  logic [STAGES-1:0]     valid_q, valid_d;
  logic [STAGES-1:0]     wb_en_q, wb_en_d;
  logic [REG_ADDR_W-1:0] dst_q [STAGES];
  logic [REG_ADDR_W-1:0] dst_d [STAGES];
  logic                  ld0_q, ld0_d;
  logic [STAT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic [STAGES-1:0]     match1, match2;
  logic                  hazard_c;
  logic [FS_W-1:0]       sel1_c, sel2_c;

  // Per-entry RAW match for each operand; register 0 never matches.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < STAGES; k++) begin
      match1[k] = id_valid && id_src1_used && valid_q[k] && wb_en_q[k] &&
                  (dst_q[k] == id_src1) && (dst_q[k] != '0);
      match2[k] = id_valid && id_src2_used && valid_q[k] && wb_en_q[k] &&
                  (dst_q[k] == id_src2) && (dst_q[k] != '0);
    end
  end

  if (FWD_EN) begin : g_fwd
    // Select of the youngest (lowest-index) matching producer.
    function automatic logic [FS_W-1:0] youngest(input logic [STAGES-1:0] m);
      logic [FS_W-1:0] sel;
      sel = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (m[k]) sel = FS_W'(k + 1);
      end
      // The last stage writes the RF in the same cycle ID reads it.
      if (RF_WRITE_THROUGH && (sel == FS_W'(STAGES))) sel = '0;
      return sel;
    endfunction

    // Entry 0 is always the youngest when it matches, so load-use reduces to it.
    always_comb begin
      sel1_c   = youngest(match1);
      sel2_c   = youngest(match2);
      hazard_c = ld0_q && (match1[0] || match2[0]);
    end
  end else begin : g_interlock
    logic unused_ld0;
    assign unused_ld0 = ld0_q;

    always_comb begin
      sel1_c   = '0;
      sel2_c   = '0;
      hazard_c = |((match1 | match2) & IL_MASK);
    end
  end

  // Shadow advance and stall counting; everything holds under freeze.
  always_comb begin
    valid_d     = valid_q;
    wb_en_d     = wb_en_q;
    dst_d       = dst_q;
    ld0_d       = ld0_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        valid_d[k] = valid_q[k-1];
        wb_en_d[k] = wb_en_q[k-1];
        dst_d[k]   = dst_q[k-1];
      end
      // Stall or flush turns the ID slot into a bubble.
      valid_d[0] = id_valid && !hazard_c && !flush;
      wb_en_d[0] = id_wb_en;
      dst_d[0]   = id_dst;
      ld0_d      = id_is_load;
      if (hazard_c && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + STAT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      wb_en_q     <= '0;
      ld0_q       <= 1'b0;
      stall_cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dst_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      wb_en_q     <= wb_en_d;
      ld0_q       <= ld0_d;
      stall_cnt_q <= stall_cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        dst_q[k] <= dst_d[k];
      end
    end
  end

  assign hazard    = hazard_c;
  assign fwd_sel1  = sel1_c;
  assign fwd_sel2  = sel2_c;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (interlock, forwarding,
// 2-bit-counter interlock) driven by directed vectors; expectations are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       valid;
    logic [4:0] src1;
    logic       u1;
    logic [4:0] src2;
    logic       u2;
    logic [4:0] dst;
    logic       wb;
    logic       ld;
    logic       freeze;
    logic       flush;
  } stim_t;

  typedef struct {
    int    cyc;
    int    dut;
    bit    haz;
    int    s1;
    int    s2;
    int    cnt;
    string name;
  } exp_t;

  logic        clk;
  logic        rst_n [3];
  stim_t       stim  [3];
  logic        haz_w [3];
  logic [1:0]  sel1_w [3];
  logic [1:0]  sel2_w [3];
  logic [15:0] cnt_il, cnt_fw;
  logic [1:0]  cnt_sat;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  hazard_scoreboard #(.FWD_EN(1'b0)) u_il (
    .clk(clk), .rst_n(rst_n[0]), .id_valid(stim[0].valid),
    .id_src1(stim[0].src1), .id_src2(stim[0].src2),
    .id_src1_used(stim[0].u1), .id_src2_used(stim[0].u2),
    .id_dst(stim[0].dst), .id_wb_en(stim[0].wb), .id_is_load(stim[0].ld),
    .freeze(stim[0].freeze), .flush(stim[0].flush),
    .hazard(haz_w[0]), .fwd_sel1(sel1_w[0]), .fwd_sel2(sel2_w[0]),
    .stall_cnt(cnt_il)
  );

  hazard_scoreboard #(.FWD_EN(1'b1)) u_fw (
    .clk(clk), .rst_n(rst_n[1]), .id_valid(stim[1].valid),
    .id_src1(stim[1].src1), .id_src2(stim[1].src2),
    .id_src1_used(stim[1].u1), .id_src2_used(stim[1].u2),
    .id_dst(stim[1].dst), .id_wb_en(stim[1].wb), .id_is_load(stim[1].ld),
    .freeze(stim[1].freeze), .flush(stim[1].flush),
    .hazard(haz_w[1]), .fwd_sel1(sel1_w[1]), .fwd_sel2(sel2_w[1]),
    .stall_cnt(cnt_fw)
  );

  hazard_scoreboard #(.FWD_EN(1'b0), .STAT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n[2]), .id_valid(stim[2].valid),
    .id_src1(stim[2].src1), .id_src2(stim[2].src2),
    .id_src1_used(stim[2].u1), .id_src2_used(stim[2].u2),
    .id_dst(stim[2].dst), .id_wb_en(stim[2].wb), .id_is_load(stim[2].ld),
    .freeze(stim[2].freeze), .flush(stim[2].flush),
    .hazard(haz_w[2]), .fwd_sel1(sel1_w[2]), .fwd_sel2(sel2_w[2]),
    .stall_cnt(cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int act_cnt(input int d);
    if (d == 0) return int'(cnt_il);
    if (d == 1) return int'(cnt_fw);
    return int'(cnt_sat);
  endfunction

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if ((haz_w[e.dut] !== e.haz) || (sel1_w[e.dut] !== 2'(e.s1)) ||
          (sel2_w[e.dut] !== 2'(e.s2)) || (act_cnt(e.dut) != e.cnt)) begin
        errors++;
        $display("FAIL %s (dut%0d cyc%0d): got hazard=%0b sel1=%0d sel2=%0d cnt=%0d, want hazard=%0b sel1=%0d sel2=%0d cnt=%0d",
                 e.name, e.dut, cyc, haz_w[e.dut], sel1_w[e.dut], sel2_w[e.dut],
                 act_cnt(e.dut), e.haz, e.s1, e.s2, e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input bit h, input int s1, input int s2,
                          input int c, input string name);
    exp_t e;
    e.cyc = cyc; e.dut = d; e.haz = h; e.s1 = s1; e.s2 = s2; e.cnt = c;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic set_id(input int d, input bit v, input int s1, input bit u1,
                        input int s2, input bit u2, input int dst,
                        input bit wb, input bit ld);
    stim[d].valid = v;
    stim[d].src1  = 5'(s1);
    stim[d].u1    = u1;
    stim[d].src2  = 5'(s2);
    stim[d].u2    = u2;
    stim[d].dst   = 5'(dst);
    stim[d].wb    = wb;
    stim[d].ld    = ld;
  endtask

  task automatic idle(input int d);
    set_id(d, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    stim[d].freeze = 1'b0;
    stim[d].flush  = 1'b0;
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  initial begin
    // Reset with stale, hazard-looking inputs on every instance.
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      set_id(d, 1'b1, 3, 1'b1, 3, 1'b1, 3, 1'b1, 1'b1);
      stim[d].freeze = 1'b0;
      stim[d].flush  = 1'b0;
    end
    tick();
    for (int d = 0; d < 3; d++) push_exp(d, 1'b0, 0, 0, 0, "reset_state");
    tick();
    for (int d = 0; d < 3; d++) push_exp(d, 1'b0, 0, 0, 0, "reset_after_edge");
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b1;
      idle(d);
    end
    tick();

    // Forwarding instance.
    set_id(1, 1, 0, 0, 0, 0, 3, 1, 0); push_exp(1, 0, 0, 0, 0, "fw_first_issue");      tick();
    set_id(1, 1, 3, 1, 0, 0, 5, 1, 0); push_exp(1, 0, 1, 0, 0, "fw_alu_b2b");          tick();
    set_id(1, 1, 3, 1, 0, 0, 0, 0, 0); push_exp(1, 0, 2, 0, 0, "fw_alu_gap1");         tick();
    set_id(1, 1, 3, 1, 5, 1, 5, 1, 0); push_exp(1, 0, 0, 2, 0, "fw_gap2_and_dual");    tick();
    set_id(1, 1, 5, 1, 0, 0, 0, 0, 0); push_exp(1, 0, 1, 0, 0, "fw_youngest_wins");    tick();
    set_id(1, 1, 0, 0, 0, 0, 4, 1, 1); push_exp(1, 0, 0, 0, 0, "fw_lw_issue");         tick();
    set_id(1, 1, 0, 0, 4, 1, 6, 1, 0); push_exp(1, 1, 0, 1, 0, "fw_load_use_stall");   tick();
    push_exp(1, 0, 0, 2, 1, "fw_load_use_resolved");                                   tick();
    set_id(1, 1, 0, 0, 0, 0, 7, 1, 1); push_exp(1, 0, 0, 0, 1, "fw_lw2_issue");        tick();
    set_id(1, 1, 7, 1, 0, 0, 8, 1, 0);
    stim[1].freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(1, 1, 1, 0, 1, "fw_freeze_hold");
      tick();
    end
    stim[1].freeze = 1'b0;
    push_exp(1, 1, 1, 0, 1, "fw_freeze_release");                                      tick();
    push_exp(1, 0, 2, 0, 2, "fw_after_freeze");                                        tick();
    set_id(1, 1, 0, 0, 0, 0, 14, 1, 0);
    stim[1].flush = 1'b1;
    push_exp(1, 0, 0, 0, 2, "fw_flush_issue");                                         tick();
    stim[1].flush = 1'b0;
    set_id(1, 1, 14, 1, 0, 0, 0, 0, 0); push_exp(1, 0, 0, 0, 2, "fw_flushed_no_match"); tick();

    // Mid-stall asynchronous reset on the forwarding instance.
    set_id(1, 1, 0, 0, 0, 0, 4, 1, 1); push_exp(1, 0, 0, 0, 2, "rst_lw_issue");        tick();
    set_id(1, 1, 0, 0, 4, 1, 0, 0, 0);
    stim[1].freeze = 1'b1;
    push_exp(1, 1, 0, 1, 2, "rst_pre_stall");                                          tick();
    rst_n[1] = 1'b0;
    push_exp(1, 0, 0, 0, 0, "rst_async_drop");                                         tick();
    rst_n[1] = 1'b1;
    stim[1].freeze = 1'b0;
    push_exp(1, 0, 0, 0, 0, "rst_release_no_stall");                                   tick();
    idle(1);

    // Interlock instance.
    set_id(0, 1, 0, 0, 0, 0, 3, 1, 0);  push_exp(0, 0, 0, 0, 0, "il_issue");           tick();
    set_id(0, 1, 3, 1, 0, 0, 9, 1, 0);  push_exp(0, 1, 0, 0, 0, "il_b2b_stall1");      tick();
    push_exp(0, 1, 0, 0, 1, "il_b2b_stall2");                                          tick();
    push_exp(0, 0, 0, 0, 2, "il_b2b_go");                                              tick();
    set_id(0, 1, 0, 0, 0, 0, 10, 1, 0); push_exp(0, 0, 0, 0, 2, "il_issue_r10");       tick();
    set_id(0, 1, 0, 0, 0, 0, 0, 0, 0);  push_exp(0, 0, 0, 0, 2, "il_nop");             tick();
    set_id(0, 1, 10, 1, 0, 0, 0, 0, 0); push_exp(0, 1, 0, 0, 2, "il_gap1_stall");      tick();
    push_exp(0, 0, 0, 0, 3, "il_gap1_go");                                             tick();
    set_id(0, 1, 0, 0, 0, 0, 11, 1, 0); push_exp(0, 0, 0, 0, 3, "il_issue_r11");       tick();
    set_id(0, 1, 0, 0, 0, 0, 0, 0, 0);  push_exp(0, 0, 0, 0, 3, "il_nop2a");           tick();
    push_exp(0, 0, 0, 0, 3, "il_nop2b");                                               tick();
    set_id(0, 1, 11, 1, 0, 0, 0, 0, 0); push_exp(0, 0, 0, 0, 3, "il_gap2_free");       tick();
    set_id(0, 1, 0, 0, 0, 0, 0, 1, 0);  push_exp(0, 0, 0, 0, 3, "il_issue_r0");        tick();
    set_id(0, 1, 0, 1, 0, 0, 12, 1, 0); push_exp(0, 0, 0, 0, 3, "il_r0_no_hazard");    tick();
    set_id(0, 1, 12, 0, 0, 0, 13, 0, 0); push_exp(0, 0, 0, 0, 3, "il_unused_src");     tick();
    set_id(0, 1, 13, 1, 0, 0, 0, 0, 0); push_exp(0, 0, 0, 0, 3, "il_no_wb_en");        tick();
    idle(0);

    // 2-bit counter saturation: three back-to-back dependences, six stalls.
    set_id(2, 1, 0, 0, 0, 0, 3, 1, 0);  push_exp(2, 0, 0, 0, 0, "sat_issue");          tick();
    set_id(2, 1, 3, 1, 0, 0, 3, 1, 0);
    for (int r = 0; r < 3; r++) begin
      push_exp(2, 1, 0, 0, sat3(2*r),     "sat_stall1"); tick();
      push_exp(2, 1, 0, 0, sat3(2*r + 1), "sat_stall2"); tick();
      push_exp(2, 0, 0, 0, sat3(2*r + 2), "sat_go");     tick();
    end
    idle(2);

    // Drain: the monitor gets a bounded number of cycles to consume the queue.
    for (int i = 0; i < 5 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
